// File: rtl/control_timer_unit.sv
// ---------------------------------------------------------------------------
// control_timer_unit
//
// Keypad-entry and timebase front end for the countdown timer datapath.
//   * Synchronizes a 10-key one-hot keypad, priority-encodes it to a BCD digit
//     (highest pressed key wins) and issues a one-cycle active-low load strobe
//     on each new press while entry is enabled.
//   * Divides the system clock into a 50 % duty square wave that clocks the
//     downstream BCD countdown counters.
//
// Optional feature: define CONTROL_TIMER_DEBOUNCE_EN to insert a debounce
// filter between the synchronizer and the key FSM. When undefined the FSM
// sees the synchronizer output directly and DEBOUNCE_CYCLES is ignored.
//
// Parameters
//   CLK_DIV          system clocks per pgt_1Hz period (even, >= 2)
//   DEBOUNCE_CYCLES  consecutive stable samples before a code is accepted
//                    (1..255, debounce builds only)
// Ports
//   clk       in   system clock, rising edge
//   resetn    in   asynchronous active-low reset
//   keyboard  in   [9:0] keypad, bit i = key for digit i pressed
//   enablen   in   active-low entry enable (0 = keys accepted)
//   d         out  [3:0] BCD of last accepted key
//   loadn     out  active-low load strobe, one cycle per accepted key
//   pgt_1Hz   out  divided clock, period CLK_DIV cycles
// ---------------------------------------------------------------------------
module control_timer_unit #(
  parameter int CLK_DIV         = 100,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [9:0] keyboard,
  input  logic       enablen,
  output logic [3:0] d,
  output logic       loadn,
  output logic       pgt_1Hz
);

  // Code used internally for "no key pressed"; never a valid BCD digit.
  localparam logic [3:0] KEY_NONE = 4'hF;

  localparam int HALF  = CLK_DIV / 2;
  localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF - 1);

  // -------------------------------------------------------------------------
  // Two-flop synchronizer
  // -------------------------------------------------------------------------
  logic [9:0] key_meta_reg;
  logic [9:0] key_sync_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      key_meta_reg <= '0;
      key_sync_reg <= '0;
    end else begin
      key_meta_reg <= keyboard;
      key_sync_reg <= key_meta_reg;
    end
  end

  // -------------------------------------------------------------------------
  // Priority encoder: later (higher) bits overwrite lower ones, so the
  // highest pressed key wins.
  // -------------------------------------------------------------------------
  logic [3:0] raw_code;

  always_comb begin
    raw_code = KEY_NONE;
    for (int i = 0; i < 10; i++) begin
      if (key_sync_reg[i]) begin
        raw_code = 4'(i);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Code seen by the key FSM
  // -------------------------------------------------------------------------
  logic [3:0] fsm_code;

`ifdef CONTROL_TIMER_DEBOUNCE_EN
  localparam logic [7:0] DEB_N = 8'(DEBOUNCE_CYCLES);

  logic [3:0] deb_last_reg;
  logic [3:0] deb_code_reg;
  logic [7:0] deb_cnt_reg;
  logic [7:0] deb_cnt_next;

  // deb_cnt counts consecutive edges at which raw_code has held its current
  // value (including the edge where it first appears). It saturates at DEB_N;
  // the filtered code is refreshed whenever the count reaches DEB_N, so a
  // change becomes visible DEBOUNCE_CYCLES edges after it first appears.
  always_comb begin
    if (raw_code != deb_last_reg) begin
      deb_cnt_next = 8'd1;
    end else if (deb_cnt_reg >= DEB_N) begin
      deb_cnt_next = DEB_N;
    end else begin
      deb_cnt_next = deb_cnt_reg + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      deb_last_reg <= KEY_NONE;
      deb_code_reg <= KEY_NONE;
      deb_cnt_reg  <= '0;
    end else begin
      deb_last_reg <= raw_code;
      deb_cnt_reg  <= deb_cnt_next;
      if (deb_cnt_next == DEB_N) begin
        deb_code_reg <= raw_code;
      end
    end
  end

  assign fsm_code = deb_code_reg;
`else
  // Debounce not built: parameter kept only for a uniform interface.
  logic cfg_unused;
  assign cfg_unused = (DEBOUNCE_CYCLES != 0);
  assign fsm_code   = raw_code;
`endif

  // -------------------------------------------------------------------------
  // Key FSM: a press is only reported on the IDLE->HELD transition, so
  // rolling from one key to another without release produces no event, and
  // a key already held when enablen falls never fires.
  // -------------------------------------------------------------------------
  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } key_state_t;

  key_state_t state_reg;
  key_state_t state_next;
  logic       accept;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (fsm_code != KEY_NONE) begin
          state_next = HELD;
          accept     = ~enablen;
        end
      end
      HELD: begin
        if (fsm_code == KEY_NONE) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered outputs. accept can only be high in IDLE and always moves the
  // FSM to HELD, so the strobe cannot last more than one cycle.
  logic [3:0] d_reg;
  logic       loadn_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      d_reg     <= 4'd0;
      loadn_reg <= 1'b1;
    end else begin
      loadn_reg <= ~accept;
      if (accept) begin
        d_reg <= fsm_code;
      end
    end
  end

  assign d     = d_reg;
  assign loadn = loadn_reg;

  // -------------------------------------------------------------------------
  // Clock divider: count 0..HALF-1, toggle the output on each wrap.
  // -------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt_reg;
  logic             pgt_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_cnt_reg <= '0;
      pgt_reg     <= 1'b0;
    end else if (div_cnt_reg == DIV_LAST) begin
      div_cnt_reg <= '0;
      pgt_reg     <= ~pgt_reg;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

  assign pgt_1Hz = pgt_reg;

endmodule

// File: tb/tb_control_timer_unit.sv
// ---------------------------------------------------------------------------
// tb_control_timer_unit
//
// Directed stimulus for control_timer_unit. Each press that should produce a
// load strobe pushes the expected digit and the expected strobe cycle into a
// queue; an independent negedge monitor pops the queue whenever loadn is low
// and also compares pgt_1Hz against a cycle-count model every cycle.
// Define CONTROL_TIMER_DEBOUNCE_EN to exercise the debounce build.
// ---------------------------------------------------------------------------
module tb_control_timer_unit;

  localparam int CLK_DIV = 100;
  localparam int HALF    = CLK_DIV / 2;
  localparam int DEB     = 4;
`ifdef CONTROL_TIMER_DEBOUNCE_EN
  localparam int LAT = 3 + DEB;
`else
  localparam int LAT = 3;
`endif

  logic       clk;
  logic       resetn;
  logic [9:0] keyboard;
  logic       enablen;
  logic [3:0] d;
  logic       loadn;
  logic       pgt_1Hz;

  control_timer_unit #(
    .CLK_DIV        (CLK_DIV),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .keyboard(keyboard),
    .enablen (enablen),
    .d       (d),
    .loadn   (loadn),
    .pgt_1Hz (pgt_1Hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising edges since resetn was released.
  int cyc;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  typedef struct {
    logic [3:0] dig;
    int         at;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Monitor: divider model and scoreboard for load strobes.
  always @(negedge clk) begin
    logic exp_pgt;
    exp_t e;
    if (resetn === 1'b1) begin
      exp_pgt = 1'((cyc / HALF) % 2);
      checks++;
      if (pgt_1Hz !== exp_pgt) begin
        failures++;
        $display("FAIL pgt_1Hz cyc=%0d got=%b exp=%b", cyc, pgt_1Hz, exp_pgt);
      end
      if (loadn !== 1'b1) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_loadn cyc=%0d loadn=%b d=%0d exp=no strobe", cyc, loadn, d);
        end else begin
          e = sb_q.pop_front();
          if (d !== e.dig || cyc != e.at) begin
            failures++;
            $display("FAIL load_event got d=%0d cyc=%0d exp d=%0d cyc=%0d", d, cyc, e.dig, e.at);
          end else begin
            $display("load d=%0d cyc=%0d ok", d, cyc);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive the keypad just after a negedge; if a strobe is expected, queue it.
  task automatic press(input logic [9:0] k, input logic fires, input logic [3:0] dig);
    exp_t e;
    keyboard = k;
    if (fires) begin
      e.dig = dig;
      e.at  = cyc + LAT;
      sb_q.push_back(e);
    end
  endtask

  task automatic check_eq(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end else begin
      $display("check %s = %0d ok", name, got);
    end
  endtask

  initial begin
    logic prev_pgt;
    int   guard;

    resetn   = 1'b0;
    keyboard = '0;
    enablen  = 1'b1;
    tick(3);
    check_eq("reset_d", int'(d), 0);
    check_eq("reset_loadn", int'(loadn), 1);
    check_eq("reset_pgt", int'(pgt_1Hz), 0);
    resetn = 1'b1;

    // Idle: divider runs, no strobes.
    tick(200);
    check_eq("idle_d", int'(d), 0);

    // Press 9 and hold.
    enablen = 1'b0;
    press(10'b1000000000, 1'b1, 4'd9);
    tick(100);
    check_eq("d_after_9", int'(d), 9);
    press(10'b0, 1'b0, 4'd0);
    tick(20);

    // Press 8 after release.
    press(10'b0100000000, 1'b1, 4'd8);
    tick(20);
    check_eq("d_after_8", int'(d), 8);
    press(10'b0, 1'b0, 4'd0);
    tick(20);

    // Roll 9 -> 8 without release: only the 9 fires.
    press(10'b1000000000, 1'b1, 4'd9);
    tick(20);
    press(10'b0100000000, 1'b0, 4'd0);
    tick(20);
    check_eq("d_after_roll", int'(d), 9);
    press(10'b0, 1'b0, 4'd0);
    tick(20);

    // Entry disabled: no strobe, d unchanged.
    enablen = 1'b1;
    press(10'b0100000000, 1'b0, 4'd0);
    tick(20);
    press(10'b0, 1'b0, 4'd0);
    tick(20);
    check_eq("d_disabled", int'(d), 9);

    // Key held while enablen falls does not fire; re-press does.
    press(10'b0010000000, 1'b0, 4'd0);
    tick(20);
    enablen = 1'b0;
    tick(20);
    check_eq("d_held_enable", int'(d), 9);
    press(10'b0, 1'b0, 4'd0);
    tick(20);
    press(10'b0010000000, 1'b1, 4'd7);
    tick(20);
    check_eq("d_repress_7", int'(d), 7);
    press(10'b0, 1'b0, 4'd0);
    tick(20);

    // Multiple keys: highest wins.
    press(10'b0000100100, 1'b1, 4'd5);
    tick(20);
    check_eq("d_multi", int'(d), 5);
    press(10'b0, 1'b0, 4'd0);
    tick(20);

`ifdef CONTROL_TIMER_DEBOUNCE_EN
    // Two-cycle glitch is filtered out.
    press(10'b0000001000, 1'b0, 4'd0);
    tick(2);
    press(10'b0, 1'b0, 4'd0);
    tick(20);
    check_eq("d_glitch", int'(d), 5);
`endif

    // Align to a pgt_1Hz rise so the reset lands while it is high.
    prev_pgt = pgt_1Hz;
    guard    = 0;
    tick(1);
    while (!(pgt_1Hz === 1'b1 && prev_pgt === 1'b0) && guard < 300) begin
      prev_pgt = pgt_1Hz;
      tick(1);
      guard++;
    end
    checks++;
    if (guard >= 300) begin
      failures++;
      $display("FAIL pgt_rise_timeout got=no rise exp=rise within 300 cycles");
    end

    // Press 3, reset asynchronously while the strobe is active.
    press(10'b0000001000, 1'b1, 4'd3);
    tick(LAT);
    check_eq("d_stable_3", int'(d), 3);
    check_eq("pgt_before_reset", int'(pgt_1Hz), 1);
    #1 resetn = 1'b0;
    #1;
    check_eq("midreset_loadn", int'(loadn), 1);
    check_eq("midreset_d", int'(d), 0);
    check_eq("midreset_pgt", int'(pgt_1Hz), 0);
    keyboard = '0;
    tick(3);
    resetn = 1'b1;
    tick(10);
    check_eq("post_reset_d", int'(d), 0);

    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      checks++;
      failures++;
      $display("FAIL missing_loadn got=no strobe exp d=%0d cyc=%0d", e.dig, e.at);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_timer_unit.md
# control_timer_unit

Keypad-entry and timebase front end for the countdown timer datapath. Converts a 10-key one-hot keypad into a BCD digit with a single-cycle active-low load strobe, gated by an active-low enable. Also divides the system clock into the 1 Hz square wave that clocks the downstream BCD countdown counters. The module is named `control_timer_unit`.

## Interface
- `CLK_DIV`, 100: system clocks per `pgt_1Hz` period; must be even, ≥2. Silicon builds override with the board frequency.
- `DEBOUNCE_CYCLES`, 4: consecutive stable samples required before a key is accepted. Used only when debounce is compiled in; range 1–255.
- `clk`  input  1  system clock; all state is updated on its rising edge.
- `resetn`  input  1  reset, asynchronous, active-low.
- `keyboard`  input  10  keypad; bit i high means key for digit i is pressed.
- `enablen`  input  1  active-low entry enable; 0 = keys accepted.
- `d`  output  4  BCD of the last accepted key, 0–9.
- `loadn`  output  1  active-low load strobe, one cycle per accepted key.
- `pgt_1Hz`  output  1  divided clock, 50 % duty, period `CLK_DIV` cycles.

## Operation
- Reset (`resetn`=0, asynchronous): `d`=0, `loadn`=1, `pgt_1Hz`=0, divider count 0, synchronizers cleared, key state = NONE, debounce count 0.
- `keyboard` passes through a 2-flop synchronizer.
- Encoding: highest set bit wins when several keys are set. For example, 10'b1000000001 encodes as 9. All-zero encodes as NONE.
- Key FSM has two states, IDLE and HELD.
  - IDLE → HELD when the synchronized (and, if enabled, debounced) code becomes a digit.
  - HELD → IDLE only when the code returns to NONE. Changing from one key to another without releasing produces no event.
- Accept event: the IDLE→HELD transition while `enablen`=0. On the cycle after the event:
  - `d` = encoded digit;
  - `loadn` = 0 for exactly one cycle.
- `d` holds its value until the next accept; it never returns to 0 except on reset.
- With `enablen`=1, the FSM still tracks presses, but no strobe is issued and `d` does not change. A key held while `enablen` falls does not fire; it must be released and pressed again.
- Divider:
  - counter runs 0..`CLK_DIV`/2−1 and wraps;
  - `pgt_1Hz` toggles on each wrap;
  - it runs regardless of `enablen` and keyboard activity.

## Timing
- Key latency, debounce out: keyboard change before edge 1 is captured by the synchronizer at edges 1–2, the event is registered at edge 3, and `loadn`=0 and the new `d` are valid from edge 3 to edge 4.
- Key latency, debounce in: 3 + `DEBOUNCE_CYCLES` edges.
- `loadn` is never low for two consecutive cycles.
- Release latency back to IDLE equals the press latency.
- `pgt_1Hz` timing:
  - first rises at edge `CLK_DIV`/2 after `resetn` deasserts;
  - toggles every `CLK_DIV`/2 edges after that;
  - with the default of 100: high after edge 50, low after edge 100.
- Reset asserted mid-strobe forces `loadn`=1 immediately. Reset asserted mid-period forces `pgt_1Hz`=0 immediately.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `CONTROL_TIMER_DEBOUNCE_EN` defined:
  - the synchronized code must stay unchanged for `DEBOUNCE_CYCLES` consecutive edges before the FSM sees it, for both press and release;
  - any change restarts the count.
- `CONTROL_TIMER_DEBOUNCE_EN` undefined: the FSM uses the synchronizer output directly, and the `DEBOUNCE_CYCLES` parameter is ignored.

## Test plan
- Reset then idle for 200 cycles with `keyboard`=0 → `d`=0, `loadn` stays 1, `pgt_1Hz` has rising edges at cycles 50 and 150 and falling edge at 100.
- `enablen`=0, `keyboard`=10'b1000000000 held 100 cycles → exactly one `loadn` low pulse at the stated latency, `d`=9 thereafter.
- Release, then `keyboard`=10'b0100000000 → one pulse, `d`=8. Switching directly from 9 to 8 without release → no pulse, `d` stays 9.
- `enablen`=1, press 10'b0100000000 and release → no pulse, `d` unchanged. Press held while `enablen` falls → still no pulse until release and re-press.
- Multiple keys 10'b0000100100 → `d`=5.
- Debounce build: a 2-cycle glitch on bit 3 → no pulse. A stable press of ≥4 cycles → one pulse with `d`=3. Mid-pulse `resetn`=0 → `loadn`=1, `d`=0, `pgt_1Hz`=0 asynchronously.
